mulf32_seq: RTL and testbench
=============================

MULF32_SEQ -- requirements
Module: mulf32_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request pulse, sampled only in IDLE.
REQ-004 SHALL have port a, input, 32 bits: IEEE-754 single multiplicand, captured when start is accepted.
REQ-005 SHALL have port b, input, 32 bits: IEEE-754 single multiplier, captured with a.
REQ-006 SHALL have port p, output, 32 bits: product, valid from the done cycle, held until the next done.
REQ-007 SHALL have port busy, output, 1 bit: high from the cycle after acceptance through the done cycle.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking p, ovf and unf valid.
REQ-009 SHALL have port ovf, output, 1 bit: exponent overflow flag for the current result.
REQ-010 SHALL have port unf, output, 1 bit: exponent underflow flag for the current result.

Function
REQ-011 SHALL implement FSM states IDLE, MUL, PACK, DONE; IDLE->MUL on start; MUL->PACK after 24 cycles; PACK->DONE; DONE->IDLE.
REQ-012 SHALL, on acceptance, latch a and b and form 24-bit mantissas with the hidden bit; exponent field 0 is treated as zero (denormals flushed).
REQ-013 SHALL, in MUL, perform one shift-add step per cycle with a 5-bit counter 0..23, building a 48-bit product.
REQ-014 SHALL, in PACK, normalise: if prod[47]=1, mantissa=prod[46:24] and exp+1; else mantissa=prod[45:23]; rounding toward zero (truncate).
REQ-015 SHALL compute biased exponent as ea+eb-127 (+1 if normalised up) in at least 10-bit signed width, so no wrap occurs.
REQ-016 SHALL, when biased exponent >=255, output signed infinity (exp 0xFF, mantissa 0) with ovf=1.
REQ-017 SHALL, when biased exponent <=0, output signed zero with unf=1.
REQ-018 SHALL set sign = sa XOR sb for all non-NaN results.
REQ-019 SHALL, when either operand is zero and neither is Inf or NaN, output signed zero with ovf=0 and unf=0.
REQ-020 SHALL, when an operand is Inf and the other is finite nonzero, output signed infinity with ovf=0.
REQ-021 SHALL, when either operand is NaN or the operands are Inf*0, output 0x7FC00000.
REQ-022 SHALL use fixed latency: done asserts exactly 26 cycles after the rising edge that sampled start, including special-case operands.
REQ-023 SHALL ignore start while busy=1; the in-flight operation and its result are unaffected.
REQ-024 SHALL accept start in the cycle after done (back-to-back); p holds the previous result until the new done.
REQ-025 SHALL assert busy=0 only in IDLE.

Reset
REQ-026 SHALL, with rst=1 at a rising edge, set state=IDLE, p=0, busy=0, done=0, ovf=0, unf=0, counter=0.
REQ-027 SHALL, on reset mid-operation, abandon the operation with no done pulse; start has no effect while rst=1.

Verification
REQ-028 SHALL cover: a=0x41880000 (17), b=0x40A00000 (5) -> done at +26 cycles, p=0x42AA0000 (85), ovf=0, unf=0.
REQ-029 SHALL cover: a=0x40400000 (3), b=0xC0A00000 (-5) -> p=0xC1700000 (-15); then back-to-back a=0x40B40000 (5.625), b=0x40000000 -> p=0x41340000 (11.25).
REQ-030 SHALL cover: a=b=0x7F000000 -> p=0x7F800000, ovf=1; and a=b=0x00800000 -> p=0x00000000, unf=1.
REQ-031 SHALL cover: a=0x7F800000, b=0x00000000 -> p=0x7FC00000; and a=0x80000000, b=0x40A00000 -> p=0x80000000.
REQ-032 SHALL cover: a second start pulse at cycle 10 of an operation -> ignored, single done at +26 with the first result.
REQ-033 SHALL cover: rst at cycle 12 of an operation -> no done, all outputs 0, and the next start completes normally.

Source files
------------

// File: rtl/mulf32_seq.sv
// Sequential IEEE-754 single-precision multiplier: radix-2 shift-add over 24 cycles, truncating, denormals flushed.
// Latency: done is high in the 26th cycle after the accepting edge (1 latch + 24 MUL + 1 PACK, DONE shown).
// Backpressure: none; start is ignored unless idle, p/ovf/unf hold until the next done.
module mulf32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic        unf
);

    typedef enum logic [1:0] {IDLE, MUL, PACK, DONE} state_t;

    state_t              state, state_n;
    logic [4:0]          cnt;
    logic [23:0]         ma;
    logic [47:0]         prod;
    logic                sgn;
    logic signed [9:0]   esum;
    logic                nan_r, inf_r, zero_r;

    // Operand classification on the raw inputs, captured at acceptance.
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    assign a_zero = (a[30:23] == 8'h00);
    assign b_zero = (b[30:23] == 8'h00);
    assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

    logic signed [9:0] esum_in;
    assign esum_in = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;

    // One shift-add step: add multiplicand into the upper half when the current multiplier bit is set.
    logic [24:0] step_sum;
    assign step_sum = {1'b0, prod[47:24]} + {1'b0, ma & {24{prod[0]}}};

    // Normalisation and result packing.
    logic signed [9:0] exp_n;
    logic [22:0]       mant_n;
    logic [31:0]       p_n;
    logic              ovf_n, unf_n;

    always_comb begin
        exp_n  = esum + $signed({9'd0, prod[47]});
        mant_n = prod[47] ? prod[46:24] : prod[45:23];
        p_n    = 32'd0;
        ovf_n  = 1'b0;
        unf_n  = 1'b0;
        if (nan_r) begin
            p_n = 32'h7FC0_0000;
        end else if (inf_r) begin
            p_n = {sgn, 8'hFF, 23'd0};
        end else if (zero_r) begin
            p_n = {sgn, 31'd0};
        end else if (exp_n >= 10'sd255) begin
            p_n   = {sgn, 8'hFF, 23'd0};
            ovf_n = 1'b1;
        end else if (exp_n <= 10'sd0) begin
            p_n   = {sgn, 31'd0};
            unf_n = 1'b1;
        end else begin
            p_n = {sgn, exp_n[7:0], mant_n};
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = MUL;
            MUL:     if (cnt == 5'd23) state_n = PACK;
            PACK:    state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            p      <= 32'd0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            ma     <= 24'd0;
            prod   <= 48'd0;
            sgn    <= 1'b0;
            esum   <= 10'sd0;
            nan_r  <= 1'b0;
            inf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (start) begin
                        ma     <= {~a_zero, a[22:0]};
                        prod   <= {24'd0, ~b_zero, b[22:0]};
                        sgn    <= a[31] ^ b[31];
                        esum   <= esum_in;
                        nan_r  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
                        inf_r  <= a_inf | b_inf;
                        zero_r <= a_zero | b_zero;
                        cnt    <= 5'd0;
                    end
                end
                MUL: begin
                    prod <= {step_sum, prod[23:1]};
                    cnt  <= (cnt == 5'd23) ? 5'd0 : cnt + 5'd1;
                end
                PACK: begin
                    p   <= p_n;
                    ovf <= ovf_n;
                    unf <= unf_n;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mulf32_seq.sv
// Directed-vector bench for mulf32_seq: table of operand/result records plus start-while-busy and mid-op reset sequences.
module tb_mulf32_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic [31:0] p;
    logic        busy, done, ovf, unf;

    int checks = 0;
    int errors = 0;

    mulf32_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .p     (p),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .unf   (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Starts one operation from idle; samples at each negedge (cycle k = k-th cycle after the accepting edge).
    // Optionally pulses start with other operands at cycle xs and rst at cycle rc.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input int xs, input int rc,
                          output logic [31:0] rp, output logic rov, output logic run,
                          output int dcyc, output int ndone, output logic bsy1, output logic [31:0] p25);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        dcyc = 0; ndone = 0; rp = 32'd0; rov = 1'b0; run = 1'b0; bsy1 = 1'b0; p25 = 32'd0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1)  bsy1 = busy;
            if (k == 25) p25 = p;
            if (done) begin
                ndone++;
                if (dcyc == 0) begin
                    dcyc = k; rp = p; rov = ovf; run = unf;
                end
            end
            start = (k == xs);
            if (k == xs) begin
                a = 32'h4040_0000; b = 32'h4040_0000;
            end
            rst = (k == rc);
            if (rc == 0 && done) break;
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    logic [31:0] rp, p25, prev_p;
    logic        rov, run, bsy1;
    int          dcyc, ndone;

    initial begin
        vt[0]  = '{32'h4188_0000, 32'h40A0_0000, 32'h42AA_0000, 1'b0, 1'b0};
        vt[1]  = '{32'h4040_0000, 32'hC0A0_0000, 32'hC170_0000, 1'b0, 1'b0};
        vt[2]  = '{32'h40B4_0000, 32'h4000_0000, 32'h4134_0000, 1'b0, 1'b0};
        vt[3]  = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 1'b0};
        vt[4]  = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1};
        vt[5]  = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0};
        vt[6]  = '{32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 1'b0, 1'b0};
        vt[7]  = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0};
        vt[8]  = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0};
        vt[9]  = '{32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 1'b0, 1'b0};
        vt[10] = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 1'b0, 1'b0};
        vt[11] = '{32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vt[12] = '{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b1, 1'b0};
        vt[13] = '{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1};
        vt[14] = '{32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 1'b0, 1'b0};
        vt[15] = '{32'h8000_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0, 1'b0};
        vt[16] = '{32'hFF00_0000, 32'h7F00_0000, 32'hFF80_0000, 1'b1, 1'b0};
        vt[17] = '{32'h8080_0000, 32'h0080_0000, 32'h8000_0000, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b1; a = 32'h3F80_0000; b = 32'h3F80_0000;
        repeat (3) @(negedge clk);
        chk("reset_p",    p,           32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_ovf",  {31'd0, ovf},  32'd0);
        chk("reset_unf",  {31'd0, unf},  32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Each vector is issued in the idle cycle right after the previous done (back-to-back).
        prev_p = 32'd0;
        for (int i = 0; i < 18; i++) begin
            run_op(vt[i].a, vt[i].b, 0, 0, rp, rov, run, dcyc, ndone, bsy1, p25);
            chk($sformatf("v%0d_p", i),       rp,            vt[i].p);
            chk($sformatf("v%0d_ovf", i),     {31'd0, rov},  {31'd0, vt[i].ovf});
            chk($sformatf("v%0d_unf", i),     {31'd0, run},  {31'd0, vt[i].unf});
            chk($sformatf("v%0d_latency", i), dcyc,          26);
            chk($sformatf("v%0d_busy1", i),   {31'd0, bsy1}, 32'd1);
            chk($sformatf("v%0d_phold", i),   p25,           prev_p);
            prev_p = vt[i].p;
        end

        // Second start at cycle 10 must be ignored.
        run_op(32'h3FC0_0000, 32'h3FC0_0000, 10, 0, rp, rov, run, dcyc, ndone, bsy1, p25);
        chk("ign_p",       rp,    32'h4010_0000);
        chk("ign_latency", dcyc,  26);
        chk("ign_ndone",   ndone, 1);
        @(negedge clk);
        chk("ign_idle_busy", {31'd0, busy}, 32'd0);
        chk("ign_idle_done", {31'd0, done}, 32'd0);

        // Reset at cycle 12 of an overflowing op: no done, outputs cleared.
        run_op(32'h7F00_0000, 32'h7F00_0000, 0, 12, rp, rov, run, dcyc, ndone, bsy1, p25);
        chk("rst_ndone", ndone,         0);
        chk("rst_p",     p,             32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_ovf",   {31'd0, ovf},  32'd0);
        chk("rst_unf",   {31'd0, unf},  32'd0);

        run_op(32'h4188_0000, 32'h40A0_0000, 0, 0, rp, rov, run, dcyc, ndone, bsy1, p25);
        chk("post_rst_p",       rp,   32'h42AA_0000);
        chk("post_rst_latency", dcyc, 26);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
